// File: rtl/epd_frame_sched_pkg.sv
// Shared encodings and constants for the epd frame sequencer.
// Field lengths are in bytes (one byte per cycle).
package epd_frame_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DST,
    ST_SRC,
    ST_TYP,
    ST_BODY,
    ST_IFG,
    ST_FIN
  } state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] IFG_BYTE      = 8'h00;
  localparam logic [7:0] IDLE_BYTE     = 8'h00;

  localparam int PRE_LEN  = 7;
  localparam int ADDR_LEN = 6;
  localparam int TYPE_LEN = 2;

  function automatic logic is_frame_state(input state_e s);
    return (s inside {ST_PRE, ST_SFD, ST_DST, ST_SRC, ST_TYP, ST_BODY});
  endfunction

endpackage

// File: rtl/epd_frame_sched_field_sel.sv
// Picks byte idx (0 = most significant) out of a 48-bit header field.
// Purely combinational.
module epd_field_sel (
  input  logic [47:0] field,
  input  logic [2:0]  idx,
  output logic [7:0]  sel_byte
);

  always_comb begin
    sel_byte = 8'h00;
    case (idx)
      3'd0: sel_byte = field[47:40];
      3'd1: sel_byte = field[39:32];
      3'd2: sel_byte = field[31:24];
      3'd3: sel_byte = field[23:16];
      3'd4: sel_byte = field[15:8];
      3'd5: sel_byte = field[7:0];
      default: sel_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/epd_frame_sched.sv
// Frame sequencer: emits frame_count Ethernet-like frames (preamble..body, then IFG) per start pulse.
// Outputs are registered from the next-state decode, so they change on the same edge as the state.
module epd_frame_sched
  import epd_frame_sched_pkg::*;
#(
  parameter int LEN_W    = 11,
  parameter int IFG_W    = 4,
  parameter int FRAMES_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [47:0]         dst_addr,
  input  logic [47:0]         src_addr,
  input  logic [15:0]         type_length,
  input  logic [LEN_W-1:0]    body_len,
  input  logic [7:0]          body_fill,
  input  logic [7:0]          body_last,
  input  logic [IFG_W-1:0]    ifg_len,
  input  logic [FRAMES_W-1:0] frame_count,
  input  logic                inj_ifg_cntrl,
  output logic [7:0]          data,
  output logic                control,
  output logic                busy,
  output logic                done,
  output logic [FRAMES_W-1:0] frames_sent
);

  localparam logic [LEN_W-1:0] PRE_CNT  = LEN_W'(PRE_LEN);
  localparam logic [LEN_W-1:0] ADDR_CNT = LEN_W'(ADDR_LEN);
  localparam logic [LEN_W-1:0] TYPE_CNT = LEN_W'(TYPE_LEN);
  localparam logic [LEN_W-1:0] ONE_CNT  = LEN_W'(1);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                arm_q, arm_d;
  logic                stop_q, stop_d;
  logic                skip_q, skip_d;
  logic [47:0]         dst_q, dst_d, src_q, src_d;
  logic [15:0]         typ_q, typ_d;
  logic [LEN_W-1:0]    body_q, body_d;
  logic [7:0]          fill_q, fill_d, last_q, last_d;
  logic [IFG_W-1:0]    ifg_q, ifg_d;
  logic [FRAMES_W-1:0] fc_q, fc_d;
  logic                inj_q, inj_d;
  logic [7:0]          data_q, data_d;
  logic                control_q, control_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [FRAMES_W-1:0] sent_q, sent_d;

  logic [LEN_W-1:0]    ifg_cnt;
  logic [47:0]         sel_field;
  logic [2:0]          sel_idx;
  logic [7:0]          sel_byte;

  assign ifg_cnt = {{(LEN_W-IFG_W){1'b0}}, ifg_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    stop_d  = stop_q;
    skip_d  = skip_q;
    dst_d   = dst_q;
    src_d   = src_q;
    typ_d   = typ_q;
    body_d  = body_q;
    fill_d  = fill_q;
    last_d  = last_q;
    ifg_d   = ifg_q;
    fc_d    = fc_q;
    inj_d   = inj_q;
    sent_d  = sent_q;

    case (state_q)
      ST_IDLE: begin
        // Config is latched one cycle ahead so the first byte can be registered from it.
        if (arm_q) begin
          arm_d = 1'b0;
          if (fc_q == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_PRE;
            cnt_d   = PRE_CNT;
          end
        end else if (start) begin
          arm_d  = 1'b1;
          stop_d = 1'b0;
          skip_d = 1'b0;
          sent_d = '0;
          dst_d  = dst_addr;
          src_d  = src_addr;
          typ_d  = type_length;
          body_d = (body_len == '0) ? ONE_CNT : body_len;
          fill_d = body_fill;
          last_d = body_last;
          ifg_d  = (ifg_len == '0) ? IFG_W'(1) : ifg_len;
          fc_d   = frame_count;
          inj_d  = inj_ifg_cntrl;
        end
      end

      ST_PRE, ST_SFD, ST_DST, ST_SRC, ST_TYP, ST_BODY: begin
        if (abort) begin
          state_d = ST_IFG;
          cnt_d   = ifg_cnt;
          stop_d  = 1'b1;
          skip_d  = 1'b1;
        end else if (cnt_q == ONE_CNT) begin
          case (state_q)
            ST_PRE:  begin state_d = ST_SFD;  cnt_d = ONE_CNT;  end
            ST_SFD:  begin state_d = ST_DST;  cnt_d = ADDR_CNT; end
            ST_DST:  begin state_d = ST_SRC;  cnt_d = ADDR_CNT; end
            ST_SRC:  begin state_d = ST_TYP;  cnt_d = TYPE_CNT; end
            ST_TYP:  begin state_d = ST_BODY; cnt_d = body_q;   end
            default: begin state_d = ST_IFG;  cnt_d = ifg_cnt;  end
          endcase
        end else begin
          cnt_d = cnt_q - ONE_CNT;
        end
      end

      ST_IFG: begin
        if (abort) stop_d = 1'b1;
        if (cnt_q == ONE_CNT) begin
          if (!skip_q) sent_d = sent_q + 1'b1;
          if (stop_q || abort || (sent_q + 1'b1 == fc_q)) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_PRE;
            cnt_d   = PRE_CNT;
          end
        end else begin
          cnt_d = cnt_q - ONE_CNT;
        end
      end

      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Type/length sits in the low two bytes of the zero-extended field.
  always_comb begin
    sel_field = dst_q;
    sel_idx   = 3'd6 - cnt_d[2:0];
    case (state_d)
      ST_SRC:  sel_field = src_q;
      ST_TYP:  sel_field = {32'h0, typ_q};
      default: sel_field = dst_q;
    endcase
  end

  epd_field_sel u_field_sel (
    .field    (sel_field),
    .idx      (sel_idx),
    .sel_byte (sel_byte)
  );

  always_comb begin
    data_d    = IDLE_BYTE;
    control_d = is_frame_state(state_d);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_FIN);
    done_d    = (state_d == ST_FIN);
    case (state_d)
      ST_PRE:                 data_d = PREAMBLE_BYTE;
      ST_SFD:                 data_d = SFD_BYTE;
      ST_DST, ST_SRC, ST_TYP: data_d = sel_byte;
      ST_BODY:                data_d = (cnt_d == ONE_CNT) ? last_q : fill_q;
      ST_IFG: begin
        data_d    = IFG_BYTE;
        control_d = inj_q;
      end
      default:                data_d = IDLE_BYTE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      arm_q     <= 1'b0;
      stop_q    <= 1'b0;
      skip_q    <= 1'b0;
      dst_q     <= '0;
      src_q     <= '0;
      typ_q     <= '0;
      body_q    <= '0;
      fill_q    <= '0;
      last_q    <= '0;
      ifg_q     <= '0;
      fc_q      <= '0;
      inj_q     <= 1'b0;
      data_q    <= IDLE_BYTE;
      control_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arm_q     <= arm_d;
      stop_q    <= stop_d;
      skip_q    <= skip_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      typ_q     <= typ_d;
      body_q    <= body_d;
      fill_q    <= fill_d;
      last_q    <= last_d;
      ifg_q     <= ifg_d;
      fc_q      <= fc_d;
      inj_q     <= inj_d;
      data_q    <= data_d;
      control_q <= control_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sent_q    <= sent_d;
    end
  end

  assign data        = data_q;
  assign control     = control_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = sent_q;

endmodule
